// File: rtl/ram_arbiter_pkg.sv
// Shared types and address-map constants for the IFU/LSU RAM arbiter.
package ram_arbiter_pkg;

    localparam logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000;
    localparam logic [63:0] MEM_WORDS = 64'h0000_0000_0800_0000;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Winner selection between IFU and LSU requests, plus the starvation counter update.
module ram_arb_pick #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic       if_valid,
    input  logic       ls_valid,
    input  logic [2:0] starve_cnt,
    output logic       grant_if,
    output logic       grant_ls,
    output logic [2:0] starve_next
);

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    always_comb begin
        // LSU normally wins; the IFU wins once it has been passed over STARVE_MAX times.
        grant_if    = if_valid && (!ls_valid || (starve_cnt == STARVE_LIM));
        grant_ls    = ls_valid && !grant_if;
        starve_next = starve_cnt;
        if (grant_ls && if_valid) begin
            starve_next = (starve_cnt >= STARVE_LIM) ? STARVE_LIM : starve_cnt + 3'd1;
        end else if (grant_ls || grant_if) begin
            starve_next = '0;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Single-outstanding arbiter sharing one synchronous-write RAM between the IFU and the LSU.
module ram_arbiter #(
    parameter logic [63:0] BASE_ADDR  = ram_arbiter_pkg::BASE_ADDR,
    parameter logic [63:0] MEM_WORDS  = ram_arbiter_pkg::MEM_WORDS,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [63:0] if_req_addr,
    output logic        if_resp_valid,
    input  logic        if_resp_ready,
    output logic [31:0] if_resp_data,
    output logic        if_resp_err,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic [63:0] ls_req_addr,
    input  logic        ls_req_wen,
    input  logic [63:0] ls_req_wdata,
    input  logic [63:0] ls_req_wmask,
    output logic        ls_resp_valid,
    input  logic        ls_resp_ready,
    output logic [63:0] ls_resp_rdata,
    output logic        ls_resp_err,
    output logic        ram_en,
    output logic [63:0] ram_idx,
    input  logic [63:0] ram_rdata,
    output logic [63:0] ram_wdata,
    output logic [63:0] ram_wmask,
    output logic        ram_wen
);

    import ram_arbiter_pkg::*;

    state_t      state_q, state_d;
    owner_t      owner_q;
    logic [63:0] addr_q, wdata_q, wmask_q, rdata_q;
    logic        wen_q, err_q;
    logic [2:0]  starve_q, starve_d;
    logic        grant_if, grant_ls;
    logic [63:0] offset;
    logic        in_range;

    ram_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .if_valid    (if_req_valid),
        .ls_valid    (ls_req_valid),
        .starve_cnt  (starve_q),
        .grant_if    (grant_if),
        .grant_ls    (grant_ls),
        .starve_next (starve_d)
    );

    // Subtraction form keeps the upper-bound compare free of overflow.
    assign offset   = addr_q - BASE_ADDR;
    assign in_range = (addr_q >= BASE_ADDR) && (offset < (MEM_WORDS << 3));

    always_comb begin
        state_d       = state_q;
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        if_resp_valid = 1'b0;
        ls_resp_valid = 1'b0;
        ram_en        = 1'b0;
        ram_idx       = '0;
        ram_wdata     = '0;
        ram_wmask     = '0;
        ram_wen       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if_req_ready = grant_if;
                ls_req_ready = grant_ls;
                if (grant_if || grant_ls) state_d = ACCESS;
            end
            ACCESS: begin
                if (in_range) begin
                    ram_en    = 1'b1;
                    ram_idx   = offset >> 3;
                    ram_wen   = wen_q;
                    ram_wdata = wdata_q;
                    ram_wmask = wmask_q;
                end
                state_d = RESP;
            end
            RESP: begin
                if_resp_valid = (owner_q == OWN_IF);
                ls_resp_valid = (owner_q == OWN_LS);
                if ((if_resp_valid && if_resp_ready) || (ls_resp_valid && ls_resp_ready)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset must squash a write that is mid-ACCESS before it reaches the RAM.
        if (!rst_n) begin
            if_req_ready  = 1'b0;
            ls_req_ready  = 1'b0;
            if_resp_valid = 1'b0;
            ls_resp_valid = 1'b0;
            ram_en        = 1'b0;
            ram_wen       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IF;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && (grant_if || grant_ls)) begin
                starve_q <= starve_d;
                owner_q  <= grant_ls ? OWN_LS : OWN_IF;
                addr_q   <= grant_ls ? ls_req_addr : if_req_addr;
                wen_q    <= grant_ls && ls_req_wen;
                wdata_q  <= grant_ls ? ls_req_wdata : '0;
                wmask_q  <= grant_ls ? ls_req_wmask : '0;
            end
            if (state_q == ACCESS) begin
                rdata_q <= (in_range && !wen_q) ? ram_rdata : '0;
                err_q   <= !in_range;
            end
        end
    end

    assign if_resp_data  = addr_q[2] ? rdata_q[63:32] : rdata_q[31:0];
    assign if_resp_err   = err_q;
    assign ls_resp_rdata = rdata_q;
    assign ls_resp_err   = err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_ram_arbiter;

    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] WORDS = 64'h0000_0000_0800_0000;
    localparam int          DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_ready, if_resp_err;
    logic [63:0] if_req_addr;
    logic [31:0] if_resp_data;
    logic        ls_req_valid, ls_req_ready, ls_req_wen, ls_resp_valid, ls_resp_ready, ls_resp_err;
    logic [63:0] ls_req_addr, ls_req_wdata, ls_req_wmask, ls_resp_rdata;
    logic        ram_en, ram_wen;
    logic [63:0] ram_idx, ram_rdata, ram_wdata, ram_wmask;

    logic [63:0] mem     [DEPTH];
    logic [63:0] ref_mem [DEPTH];
    logic        init_mem;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_req_addr   (if_req_addr),
        .if_resp_valid (if_resp_valid),
        .if_resp_ready (if_resp_ready),
        .if_resp_data  (if_resp_data),
        .if_resp_err   (if_resp_err),
        .ls_req_valid  (ls_req_valid),
        .ls_req_ready  (ls_req_ready),
        .ls_req_addr   (ls_req_addr),
        .ls_req_wen    (ls_req_wen),
        .ls_req_wdata  (ls_req_wdata),
        .ls_req_wmask  (ls_req_wmask),
        .ls_resp_valid (ls_resp_valid),
        .ls_resp_ready (ls_resp_ready),
        .ls_resp_rdata (ls_resp_rdata),
        .ls_resp_err   (ls_resp_err),
        .ram_en        (ram_en),
        .ram_idx       (ram_idx),
        .ram_rdata     (ram_rdata),
        .ram_wdata     (ram_wdata),
        .ram_wmask     (ram_wmask),
        .ram_wen       (ram_wen)
    );

    function automatic logic [63:0] seed(input int i);
        if (i == 2) return 64'h1122_3344_5566_7788;
        return {32'hA5A5_0000 + 32'(i), 32'h5A5A_0000 + 32'(i * 3)};
    endfunction

    // RAM model: combinational read, masked write at the rising edge; aliased to DEPTH words.
    assign ram_rdata = mem[ram_idx[5:0]];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= seed(i);
        end else if (ram_wen) begin
            mem[ram_idx[5:0]] <= (mem[ram_idx[5:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from a single requester; resp_ready held low for 'delay' extra cycles.
    task automatic txn(input bit is_if, input logic [63:0] addr, input bit wr_in,
                       input logic [63:0] wd, input logic [63:0] wm, input int delay);
        logic [63:0] off, w, word, exp_data;
        bit          inr, wr;
        wr       = wr_in && !is_if;
        off      = addr - BASE;
        inr      = (addr >= BASE) && (off < (WORDS << 3));
        w        = off >> 3;
        word     = (inr && !wr) ? ref_mem[w[5:0]] : 64'd0;
        exp_data = is_if ? (addr[2] ? {32'd0, word[63:32]} : {32'd0, word[31:0]}) : word;
        if (is_if) begin
            if_req_addr  = addr;
            if_req_valid = 1'b1;
        end else begin
            ls_req_addr  = addr;
            ls_req_wen   = wr;
            ls_req_wdata = wd;
            ls_req_wmask = wm;
            ls_req_valid = 1'b1;
        end
        #1;
        check("req_ready", 64'(is_if ? if_req_ready : ls_req_ready), 64'd1);
        tick();
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        check("ram_en", 64'(ram_en), 64'(inr));
        check("ram_wen", 64'(ram_wen), 64'(inr && wr));
        if (inr) check("ram_idx", ram_idx, w);
        tick();
        for (int d = 0; d <= delay; d++) begin
            if (d == 1) begin
                if (is_if) begin
                    ls_req_wen   = 1'b0;
                    ls_req_valid = 1'b1;
                end else begin
                    if_req_valid = 1'b1;
                end
                #1;
            end
            check("resp_valid", 64'(is_if ? if_resp_valid : ls_resp_valid), 64'd1);
            check("resp_other", 64'(is_if ? ls_resp_valid : if_resp_valid), 64'd0);
            check("resp_data", is_if ? {32'd0, if_resp_data} : ls_resp_rdata, exp_data);
            check("resp_err", 64'(is_if ? if_resp_err : ls_resp_err), 64'(!inr));
            if (d > 0) check("no_grant", 64'(if_req_ready | ls_req_ready), 64'd0);
            if (d == delay) begin
                if_req_valid  = 1'b0;
                ls_req_valid  = 1'b0;
                if_resp_ready = is_if;
                ls_resp_ready = !is_if;
            end
            tick();
        end
        if_resp_ready = 1'b0;
        ls_resp_ready = 1'b0;
        check("resp_done", 64'(if_resp_valid | ls_resp_valid), 64'd0);
        if (inr && wr) ref_mem[w[5:0]] = (ref_mem[w[5:0]] & ~wm) | (wd & wm);
    endtask

    initial begin
        logic [63:0] addr, wd, wm;
        int          ls_run, grants, bad;
        bit          exp_if;

        rst_n         = 1'b0;
        init_mem      = 1'b1;
        if_req_valid  = 1'b1;
        ls_req_valid  = 1'b1;
        if_req_addr   = BASE;
        ls_req_addr   = BASE;
        ls_req_wen    = 1'b1;
        ls_req_wdata  = '1;
        ls_req_wmask  = '1;
        if_resp_ready = 1'b0;
        ls_resp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed(i);
        tick();
        tick();
        check("rst_if_ready", 64'(if_req_ready), 64'd0);
        check("rst_ls_ready", 64'(ls_req_ready), 64'd0);
        check("rst_resp_valid", 64'(if_resp_valid | ls_resp_valid), 64'd0);
        check("rst_ram_en", 64'(ram_en | ram_wen), 64'd0);
        check("rst_ls_rdata", ls_resp_rdata, 64'd0);
        check("rst_if_data", {32'd0, if_resp_data}, 64'd0);
        check("rst_err", 64'(if_resp_err | ls_resp_err), 64'd0);
        init_mem     = 1'b0;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        ls_req_wen   = 1'b0;
        rst_n        = 1'b1;
        tick();

        // Directed reads of word 2 from both sides.
        txn(1'b0, BASE + 64'h10, 1'b0, '0, '0, 0);
        check("ls_word2_const", ls_resp_rdata, 64'h1122_3344_5566_7788);
        txn(1'b1, BASE + 64'h14, 1'b0, '0, '0, 0);
        check("if_hi_const", {32'd0, if_resp_data}, 64'h1122_3344);
        txn(1'b1, BASE + 64'h10, 1'b0, '0, '0, 1);
        check("if_lo_const", {32'd0, if_resp_data}, 64'h5566_7788);

        // Out-of-range writes on both sides of the window, then last in-range word.
        txn(1'b0, BASE - 64'd8, 1'b1, '1, '1, 0);
        txn(1'b0, BASE + (WORDS << 3), 1'b1, '1, '1, 0);
        txn(1'b0, BASE + (WORDS << 3) - 64'd8, 1'b0, '0, '0, 0);

        // Back-pressure: response held for 5 cycles.
        txn(1'b0, BASE + 64'h18, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, 64'h0000_FFFF_FFFF_0000, 5);
        txn(1'b0, BASE + 64'h18, 1'b0, '0, '0, 5);

        // Both requesters held: LSU wins until the IFU has been passed over four times.
        if_req_addr   = BASE;
        ls_req_addr   = BASE + 64'd8;
        ls_req_wen    = 1'b0;
        if_resp_ready = 1'b1;
        ls_resp_ready = 1'b1;
        if_req_valid  = 1'b1;
        ls_req_valid  = 1'b1;
        ls_run        = 0;
        grants        = 0;
        #1;
        for (int c = 0; c < 60 && grants < 10; c++) begin
            if (if_req_ready || ls_req_ready) begin
                exp_if = (ls_run == 4);
                check("grant_if", 64'(if_req_ready), 64'(exp_if));
                check("grant_excl", 64'(if_req_ready && ls_req_ready), 64'd0);
                ls_run = if_req_ready ? 0 : ls_run + 1;
                grants++;
            end
            tick();
        end
        check("grant_count", 64'(grants), 64'd10);
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        tick();
        tick();
        tick();
        if_resp_ready = 1'b0;
        ls_resp_ready = 1'b0;

        // Reset during the ACCESS cycle of a full-mask write.
        ls_req_addr  = BASE + 64'd40;
        ls_req_wen   = 1'b1;
        ls_req_wdata = ~ref_mem[5];
        ls_req_wmask = '1;
        ls_req_valid = 1'b1;
        #1;
        check("abort_ready", 64'(ls_req_ready), 64'd1);
        tick();
        ls_req_valid = 1'b0;
        ls_req_wen   = 1'b0;
        check("abort_pre_wen", 64'(ram_wen), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_wen", 64'(ram_wen), 64'd0);
        tick();
        check("abort_no_resp", 64'(ls_resp_valid), 64'd0);
        rst_n = 1'b1;
        tick();
        check("abort_idle", 64'(ls_resp_valid | if_resp_valid), 64'd0);
        check("abort_mem", mem[5], ref_mem[5]);
        txn(1'b0, BASE + 64'd40, 1'b0, '0, '0, 0);

        // Randomized single-requester traffic.
        for (int n = 0; n < 40; n++) begin
            addr = BASE + 64'($urandom_range(0, DEPTH - 1)) * 64'd8;
            if ($urandom_range(0, 7) == 0) begin
                addr = ($urandom_range(0, 1) == 0) ? BASE - 64'd8 * 64'($urandom_range(1, 9))
                                                   : BASE + (WORDS << 3) + 64'd8 * 64'($urandom_range(0, 9));
            end
            wd = {$urandom, $urandom};
            wm = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       txn(1'b1, addr + 64'd4 * 64'($urandom_range(0, 1)), 1'b0, '0, '0,
                             int'($urandom_range(0, 2)));
                1:       txn(1'b0, addr, 1'b0, '0, '0, int'($urandom_range(0, 2)));
                default: txn(1'b0, addr, 1'b1, wd, wm, int'($urandom_range(0, 2)));
            endcase
        end

        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("mem_image", 64'(bad), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
